// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iteration sequencer for the shared multiply/divide unit.
// Steps the datapath through LOAD, N RUN iterations and a one-cycle DONE,
// tracks the operation type and reports the exception with the ready pulse.
//
// Build option: define MULTDIV_DIV0_FAST_EN to make a divide-by-zero start
// skip LOAD/RUN and report DONE with the exception in the next cycle.
//
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   ctrl_MULT, ctrl_DIV    single-cycle start pulses (multiply has priority)
//   divisor_zero           divisor == 0, sampled with the start
//   mult_overflow          datapath overflow, sampled in the last multiply iteration
//   load_operands          datapath operand load strobe (LOAD)
//   iter_enable            datapath iteration strobe (RUN)
//   is_div                 latched operation type (1 = divide)
//   iteration              current 0-based iteration index
//   last_iter              final iteration of the current operation
//   busy                   LOAD, RUN or DONE
//   data_resultRDY         one-cycle result-valid pulse (DONE)
//   data_exception         overflow / divide-by-zero, valid with data_resultRDY
module multdiv_sequencer #(
  parameter int unsigned MULT_ITERS = 16,
  parameter int unsigned DIV_ITERS  = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_overflow,
  output logic             load_operands,
  output logic             iter_enable,
  output logic             is_div,
  output logic [CNT_W-1:0] iteration,
  output logic             last_iter,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             div0_q, div0_d;
  logic             ovf_q, ovf_d;

  logic             start;
  logic             start_div;
  logic [CNT_W-1:0] last_idx;
  logic             at_last;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign last_idx  = is_div_q ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MULT_ITERS - 1);
  assign at_last   = (cnt_q == last_idx);

  // State and bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic; an accepted start overrides whatever the current state wants
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: ;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (at_last) begin
          state_d = ST_DONE;
          if (!is_div_q) ovf_d = mult_overflow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_LOAD;
      is_div_d = start_div;
      div0_d   = start_div & divisor_zero;
      cnt_d    = '0;
`ifdef MULTDIV_DIV0_FAST_EN
      // Nothing to compute for a zero divisor: report straight away
      if (start_div & divisor_zero) state_d = ST_DONE;
`endif
    end
  end

  // Outputs are pure decodes of registered state
  assign load_operands  = (state_q == ST_LOAD);
  assign iter_enable    = (state_q == ST_RUN);
  assign last_iter      = (state_q == ST_RUN) & at_last;
  assign busy           = (state_q != ST_IDLE);
  assign data_resultRDY = (state_q == ST_DONE);
  assign data_exception = (state_q == ST_DONE) & (is_div_q ? div0_q : ovf_q);
  assign is_div         = is_div_q;
  assign iteration      = cnt_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
// Cycle k is the period after rising edge k-1; the start pulse is sampled at edge 0.
module tb_multdiv_sequencer;

  localparam int unsigned CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_MULT, ctrl_DIV, divisor_zero, mult_overflow;
  logic             load_operands, iter_enable, is_div, last_iter, busy;
  logic             data_resultRDY, data_exception;
  logic [CNT_W-1:0] iteration;

  multdiv_sequencer #(.MULT_ITERS(16), .DIV_ITERS(32), .CNT_W(CNT_W)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .divisor_zero   (divisor_zero),
    .mult_overflow  (mult_overflow),
    .load_operands  (load_operands),
    .iter_enable    (iter_enable),
    .is_div         (is_div),
    .iteration      (iteration),
    .last_iter      (last_iter),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    else
      n_pass++;
  endtask

  // Per-run observation record
  int cyc;
  int load_cnt, load_first, load_last;
  int iter_cnt, iter_first, iter_last, iter_bad, iter_max;
  int last_cnt, last_cyc;
  int rdy_cnt, rdy_cyc, rdy_exc, rdy_it, consec;
  int busy_cnt;
  logic prev_en, prev_rdy;
  int   prev_it;

  task automatic clear_mon();
    cyc = 0;
    load_cnt = 0; load_first = -1; load_last = -1;
    iter_cnt = 0; iter_first = -1; iter_last = -1; iter_bad = 0; iter_max = -1;
    last_cnt = 0; last_cyc = -1;
    rdy_cnt = 0; rdy_cyc = -1; rdy_exc = -1; rdy_it = -1; consec = 0;
    busy_cnt = 0;
    prev_en = 1'b0; prev_rdy = 1'b0; prev_it = 0;
  endtask

  task automatic sample();
    int exp_it;
    if (load_operands) begin
      load_cnt++;
      if (load_first < 0) load_first = cyc;
      load_last = cyc;
    end
    if (iter_enable) begin
      exp_it = prev_en ? prev_it + 1 : 0;
      if (int'(iteration) != exp_it) iter_bad++;
      iter_cnt++;
      if (iter_first < 0) iter_first = cyc;
      iter_last = cyc;
      if (int'(iteration) > iter_max) iter_max = int'(iteration);
    end
    prev_en = iter_enable;
    prev_it = int'(iteration);
    if (last_iter) begin
      last_cnt++;
      last_cyc = cyc;
    end
    if (data_resultRDY) begin
      if (prev_rdy) consec++;
      rdy_cnt++;
      rdy_cyc = cyc;
      rdy_exc = int'(data_exception);
      rdy_it  = int'(iteration);
    end
    prev_rdy = data_resultRDY;
    if (busy) busy_cnt++;
  endtask

  // Advance one cycle: pass the edge, drop start pulses, observe at the falling edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    cyc++;
    sample();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({load_operands, iter_enable, is_div, iteration, last_iter,
                busy, data_resultRDY, data_exception});
  endfunction

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    divisor_zero = 1'b0; mult_overflow = 1'b0;

    // Reset held 3 cycles, then idle with no start
    clear_mon();
    @(negedge clock);
    run(3);
    reset = 1'b0;
    check("reset_outputs", out_vec(), 32'd0);
    clear_mon();
    run(20);
    check("idle_busy_never", 32'(busy_cnt), 32'd0);
    check("idle_outputs", out_vec(), 32'd0);

    // Plain multiply, no overflow
    clear_mon();
    ctrl_MULT = 1'b1;
    run(25);
    check("mul_load_first", 32'(load_first), 32'd1);
    check("mul_load_cnt", 32'(load_cnt), 32'd1);
    check("mul_iter_first", 32'(iter_first), 32'd2);
    check("mul_iter_last", 32'(iter_last), 32'd17);
    check("mul_iter_cnt", 32'(iter_cnt), 32'd16);
    check("mul_iter_seq", 32'(iter_bad), 32'd0);
    check("mul_last_cyc", 32'(last_cyc), 32'd17);
    check("mul_last_cnt", 32'(last_cnt), 32'd1);
    check("mul_rdy_cyc", 32'(rdy_cyc), 32'd18);
    check("mul_rdy_cnt", 32'(rdy_cnt), 32'd1);
    check("mul_exc", 32'(rdy_exc), 32'd0);
    check("mul_done_iter", 32'(rdy_it), 32'd15);
    check("mul_is_div", 32'(is_div), 32'd0);
    check("mul_idle_after", out_vec(), 32'd0);

    // Multiply with overflow
    clear_mon();
    mult_overflow = 1'b1;
    ctrl_MULT = 1'b1;
    run(22);
    mult_overflow = 1'b0;
    check("mulovf_rdy_cyc", 32'(rdy_cyc), 32'd18);
    check("mulovf_exc", 32'(rdy_exc), 32'd1);

    // Divide, nonzero divisor
    clear_mon();
    ctrl_DIV = 1'b1;
    run(40);
    check("div_load_first", 32'(load_first), 32'd1);
    check("div_iter_cnt", 32'(iter_cnt), 32'd32);
    check("div_iter_max", 32'(iter_max), 32'd31);
    check("div_iter_seq", 32'(iter_bad), 32'd0);
    check("div_last_cyc", 32'(last_cyc), 32'd33);
    check("div_rdy_cyc", 32'(rdy_cyc), 32'd34);
    check("div_exc", 32'(rdy_exc), 32'd0);
    check("div_is_div", 32'(is_div), 32'd1);

    // Divide with overflow flag forced high: no exception
    clear_mon();
    mult_overflow = 1'b1;
    ctrl_DIV = 1'b1;
    run(40);
    mult_overflow = 1'b0;
    check("divovf_rdy_cyc", 32'(rdy_cyc), 32'd34);
    check("divovf_exc", 32'(rdy_exc), 32'd0);

    // Divide by zero
    clear_mon();
    ctrl_DIV = 1'b1;
    divisor_zero = 1'b1;
    step();
    divisor_zero = 1'b0;
    run(39);
`ifdef MULTDIV_DIV0_FAST_EN
    check("div0_rdy_cyc", 32'(rdy_cyc), 32'd1);
    check("div0_load_cnt", 32'(load_cnt), 32'd0);
    check("div0_iter_cnt", 32'(iter_cnt), 32'd0);
`else
    check("div0_rdy_cyc", 32'(rdy_cyc), 32'd34);
    check("div0_iter_cnt", 32'(iter_cnt), 32'd32);
`endif
    check("div0_exc", 32'(rdy_exc), 32'd1);
    check("div0_rdy_cnt", 32'(rdy_cnt), 32'd1);

    // Both starts high (multiply wins), then a divide restart at edge 10
    clear_mon();
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    step();
    check("both_is_div", 32'(is_div), 32'd0);
    run(9);
    ctrl_DIV = 1'b1;
    run(40);
    check("rst_load_last", 32'(load_last), 32'd11);
    check("rst_load_cnt", 32'(load_cnt), 32'd2);
    check("rst_rdy_cnt", 32'(rdy_cnt), 32'd1);
    check("rst_rdy_cyc", 32'(rdy_cyc), 32'd44);
    check("rst_iter_seq", 32'(iter_bad), 32'd0);
    check("rst_is_div", 32'(is_div), 32'd1);

    // Reset in cycle 9 of a multiply
    clear_mon();
    ctrl_MULT = 1'b1;
    run(9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_outputs", out_vec(), 32'd0);
    run(20);
    check("midrst_no_rdy", 32'(rdy_cnt), 32'd0);
    clear_mon();
    ctrl_MULT = 1'b1;
    run(22);
    check("after_rst_rdy_cyc", 32'(rdy_cyc), 32'd18);

    // Start accepted in the DONE cycle: back-to-back operations
    clear_mon();
    ctrl_MULT = 1'b1;
    run(18);
    check("b2b_first_rdy", 32'(data_resultRDY), 32'd1);
    ctrl_MULT = 1'b1;
    run(22);
    check("b2b_load_last", 32'(load_last), 32'd19);
    check("b2b_rdy_cnt", 32'(rdy_cnt), 32'd2);
    check("b2b_rdy_cyc", 32'(rdy_cyc), 32'd36);
    check("b2b_consec", 32'(consec), 32'd0);

    // Reset wins over a simultaneous start
    clear_mon();
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    step();
    reset = 1'b0;
    check("rstprio_outputs", out_vec(), 32'd0);
    run(3);
    check("rstprio_busy", 32'(busy_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Iteration sequencer for the shared multiply/divide unit. It accepts single-cycle `ctrl_MULT` / `ctrl_DIV` start pulses from the processor. It steps the datapath through operand load, a fixed number of iterations, and a result-ready cycle: 16 iterations for radix-4 Booth multiply, 32 for restoring divide. It tracks the operation type and reports exceptions with the ready pulse.

## Interface
Parameters:
- `MULT_ITERS`, 16, iterations per multiply (radix-4 Booth, 32-bit operands)
- `DIV_ITERS`, 32, iterations per divide
- `CNT_W`, 6, width of the iteration counter; must hold `max(MULT_ITERS, DIV_ITERS)`

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; forces IDLE
- `ctrl_MULT`  in  1  start multiply (single-cycle pulse)
- `ctrl_DIV`  in  1  start divide (single-cycle pulse)
- `divisor_zero`  in  1  divisor == 0; sampled in the start cycle
- `mult_overflow`  in  1  datapath overflow flag; sampled in the last multiply iteration
- `load_operands`  out  1  datapath loads operand/partial-product registers
- `iter_enable`  out  1  datapath performs one iteration (add/sub plus shift)
- `is_div`  out  1  latched operation type: 1 = divide, 0 = multiply
- `iteration`  out  CNT_W  current iteration index (0-based)
- `last_iter`  out  1  high during the final iteration
- `busy`  out  1  operation in progress (LOAD, RUN or DONE)
- `data_resultRDY`  out  1  one-cycle result-valid pulse
- `data_exception`  out  1  exception flag; meaningful only while `data_resultRDY` = 1

## Operation
States: IDLE, LOAD, RUN, DONE.
- **Start acceptance:**
  - A start is `ctrl_MULT | ctrl_DIV` sampled on a rising edge.
  - If both are high, multiply wins and `ctrl_DIV` is ignored.
  - A start is accepted in any state, including RUN and DONE. The current operation is abandoned and the next state is LOAD (restart semantics).
- **On an accepted start:**
  - `is_div` latches the operation type.
  - `div0_q` latches `ctrl_DIV & ~ctrl_MULT & divisor_zero`.
  - The counter clears to 0.
- **IDLE:** all outputs 0 except `is_div`, which holds its last value.
- **LOAD** (one cycle): `load_operands` = 1, `busy` = 1. Always goes to RUN.
- **RUN:**
  - `iter_enable` = 1 and `busy` = 1.
  - `iteration` increments each cycle, from 0 to N−1, where N = `MULT_ITERS` or `DIV_ITERS` per `is_div`.
  - `last_iter` = 1 when `iteration` == N−1; the next state is DONE.
  - In the `last_iter` cycle of a multiply, `ovf_q` latches `mult_overflow`.
- **DONE** (one cycle):
  - `data_resultRDY` = 1.
  - `data_exception` = `is_div ? div0_q : ovf_q`.
  - Next state is IDLE unless a start is accepted.
- **Counter:** unsigned `CNT_W` bits; never wraps in legal operation. It holds N−1 in DONE and clears to 0 on IDLE entry.
- **Reset (any cycle, including mid-operation):**
  - State goes to IDLE; `iteration`, `div0_q`, `ovf_q` and `is_div` clear to 0.
  - All outputs read 0 in the cycle after reset is sampled.
  - Reset has priority over a simultaneous start.

## Timing
- Start sampled at edge 0:
  - LOAD in cycle 1.
  - RUN in cycles 2 … N+1.
  - DONE (`data_resultRDY`) in cycle N+2.
- Multiply latency: `data_resultRDY` 18 cycles after the start edge. Divide latency: 34 cycles.
- All outputs are registered state decodes; none depend combinationally on `ctrl_MULT` / `ctrl_DIV`.
- A start in the DONE cycle:
  - `data_resultRDY` still pulses in that cycle.
  - LOAD follows in the next cycle, with no idle gap.
- `data_resultRDY` is never asserted for two consecutive cycles.

## Configuration
- `MULTDIV_DIV0_FAST_EN`:
  - **Defined:** a divide start with `divisor_zero` = 1 goes directly to DONE in the next cycle. There is no LOAD or RUN, and `iter_enable` / `load_operands` stay 0. `data_resultRDY` = 1 and `data_exception` = 1 in cycle 1.
  - **Undefined:** divide-by-zero runs the full sequence. `data_exception` = 1 is reported in cycle 34.
- Multiply behaviour is identical in both builds.

## Test plan
- Reset held 3 cycles, then released with no start → all outputs 0; `busy` = 0 indefinitely.
- `ctrl_MULT` pulse at cycle 0, `mult_overflow` = 0 → `load_operands` in cycle 1, `iter_enable` in cycles 2–17, `last_iter` in cycle 17, `data_resultRDY` = 1 with `data_exception` = 0 in cycle 18 only.
- `ctrl_DIV` pulse with `divisor_zero` = 0 → `iteration` counts 0–31, `data_resultRDY` in cycle 34, `data_exception` = 0. Repeat with `mult_overflow` forced to 1 throughout → `data_exception` still 0.
- `ctrl_DIV` with `divisor_zero` = 1 → `data_exception` = 1 with `data_resultRDY`, in cycle 34 (macro undefined) or cycle 1 (macro defined).
- `ctrl_MULT` and `ctrl_DIV` both high, then `ctrl_DIV` again at cycle 10 → `is_div` = 0 after the first start. The second start restarts the sequence: LOAD in cycle 11, `data_resultRDY` in cycle 44, and no ready pulse for the first operation.
- `reset` asserted in cycle 9 of a multiply → IDLE from cycle 10; `data_resultRDY` never asserts. A new `ctrl_MULT` afterwards completes in 18 cycles.
